cmp_pipe: RTL

Parametrised elastic pipeline that carries a data word and an operand pair through DEPTH register stages. Each stage uses a valid/ready handshake. At entry, the block computes an equality flag (a == b) and a select-mux result (sel ? a : b) and registers them alongside the data. A saturating counter tallies delivered transfers whose operands matched. The block sits between a producer and a consumer on the datapath, where it provides registered, back-pressure-aware compare results.

---
 rtl/cmp_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/cmp_pipe.sv
// cmp_pipe: elastic valid/ready pipeline of DEPTH stages that carries a payload
// word together with an equality flag and a select-mux result computed at
// entry. A saturating counter tallies delivered beats whose operands matched.
module cmp_pipe #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_eq,
  output logic [WIDTH-1:0]     out_mux,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] match_cnt
);

  logic [DEPTH-1:0]     vld_p;
  logic [DEPTH-1:0]     eq_p;
  logic [WIDTH-1:0]     data_p [DEPTH];
  logic [WIDTH-1:0]     mux_p  [DEPTH];

  logic [DEPTH-1:0]     rdy;
  logic [DEPTH-1:0]     src_vld;
  logic [DEPTH-1:0]     src_eq;
  logic [WIDTH-1:0]     src_data [DEPTH];
  logic [WIDTH-1:0]     src_mux  [DEPTH];

  logic [CNT_WIDTH-1:0] cnt;
  logic                 out_hs;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Ready chain, flattened: a stage can load if the output is taken or any
  // stage from it downstream is empty, so bubbles collapse under a stall.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!vld_p[j]) rdy[k] = 1'b1;
      end
    end
  end

  // Per-stage load sources: the input ports feed stage 0 (with the compare
  // and select evaluated here), every other stage takes its predecessor.
  always_comb begin
    src_vld[0]  = in_valid;
    src_data[0] = in_data;
    src_eq[0]   = (in_a == in_b);
    src_mux[0]  = in_sel ? in_a : in_b;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k]  = vld_p[k-1];
      src_data[k] = data_p[k-1];
      src_eq[k]   = eq_p[k-1];
      src_mux[k]  = mux_p[k-1];
    end
  end

  // Stage registers: advance when ready, payload only follows a valid beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      eq_p  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_p[k] <= '0;
        mux_p[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld_p[k] <= src_vld[k];
          if (src_vld[k]) begin
            data_p[k] <= src_data[k];
            eq_p[k]   <= src_eq[k];
            mux_p[k]  <= src_mux[k];
          end
        end
      end
    end
  end

  assign out_hs = vld_p[DEPTH-1] & out_ready;

  // Match counter: clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (out_hs && eq_p[DEPTH-1]) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[DEPTH-1];
  assign out_data  = data_p[DEPTH-1];
  assign out_eq    = eq_p[DEPTH-1];
  assign out_mux   = mux_p[DEPTH-1];
  assign match_cnt = cnt;

endmodule
